// File: rtl/kernel_stream_ctrl.sv
// Job sequencer for a fixed-latency, stall-able kernel pipeline: valid/ready on both
// stream sides, a valid shift register that shadows the kernel stages, and busy/done per job.
module kernel_stream_ctrl #(
  parameter int DATAW = 32,
  parameter int LAT   = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNTW-1:0]  nitems,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic [DATAW-1:0] k_din,
  output logic             k_stall,
  input  logic [DATAW-1:0] k_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic [CNTW-1:0]  items_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LAT-1:0]  vld;
  logic [CNTW-1:0] accepted;
  logic [CNTW-1:0] emitted;
  logic [CNTW-1:0] nitems_q;
  logic            accept;
  logic            emit;
  logic            last_accept;
  logic            last_emit;
  logic            start_run;

  // The kernel sees the stream directly; only its stall is controlled here.
  assign k_din     = in_data;
  assign out_data  = k_dout;
  assign out_valid = vld[LAT-1];
  // A bubble at the output never stalls, so the pipeline keeps compacting.
  assign k_stall   = out_valid & ~out_ready;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign items_out = emitted;

  // Comparing against nitems-1 keeps the counters inside CNTW bits even for 2^CNTW-1.
  assign last_accept = accept & (accepted == nitems_q - CNTW'(1));
  assign last_emit   = emit & (emitted == nitems_q - CNTW'(1));
  assign start_run   = (state == S_IDLE) & start & (nitems != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = (nitems == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last_accept) state_nxt = S_DRAIN;
      S_DRAIN: if (last_emit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    unique case (state)
      S_RUN: begin
        busy     = 1'b1;
        in_ready = ~k_stall & (accepted < nitems_q);
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld      <= '0;
      accepted <= '0;
      emitted  <= '0;
      nitems_q <= '0;
    end else begin
      // The valid tags move in lockstep with the kernel stages, so both freeze together.
      if (!k_stall) vld <= (vld << 1) | LAT'(accept);
      if (state == S_IDLE && start) nitems_q <= nitems;
      if (start_run) begin
        accepted <= '0;
        emitted  <= '0;
      end else begin
        if (accept) accepted <= accepted + CNTW'(1);
        if (emit)   emitted  <= emitted + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_kernel_stream_ctrl.sv
// Directed bench for kernel_stream_ctrl: a stall-able LAT-stage kernel model, a data
// scoreboard and per-job cycle statistics compared against hand-computed values.
module tb_kernel_stream_ctrl;

  localparam int DATAW = 32;
  localparam int LAT   = 4;
  localparam int CNTW  = 16;
  localparam logic [DATAW-1:0] KEY = 32'h5A5A_5A5A;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNTW-1:0]  nitems;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic [DATAW-1:0] k_din;
  logic             k_stall;
  logic [DATAW-1:0] k_dout;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic [CNTW-1:0]  items_out;

  kernel_stream_ctrl #(.DATAW(DATAW), .LAT(LAT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .nitems(nitems), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .k_din(k_din),
    .k_stall(k_stall), .k_dout(k_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .items_out(items_out)
  );

  always #5 clk = ~clk;

  // Kernel model: LAT stages that all freeze on stall, output scrambled by KEY.
  logic [DATAW-1:0] kpipe [LAT];
  always @(posedge clk) begin
    if (!k_stall) begin
      kpipe[0] <= k_din;
      for (int i = 1; i < LAT; i++) kpipe[i] <= kpipe[i-1];
    end
  end
  assign k_dout = kpipe[LAT-1] ^ KEY;

  int n_total = 0;
  int n_bad   = 0;

  int cyc, seq, n_acc, n_emit, n_done, n_stall, busy_seen, rule_bad;
  int first_acc, first_ov, last_emit, done_cyc;
  logic [63:0] acc_mask, ov_mask;
  logic [DATAW-1:0] sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic begin_test();
    cyc = 0; n_acc = 0; n_emit = 0; n_done = 0; n_stall = 0; busy_seen = 0; rule_bad = 0;
    first_acc = -1; first_ov = -1; last_emit = -1; done_cyc = -1;
    acc_mask = '0; ov_mask = '0;
    sb.delete();
  endtask

  // One cycle: drive at the falling edge, sample 1ns later, let the rising edge commit.
  task automatic step(input logic st, input logic [CNTW-1:0] n, input logic iv, input logic ordy);
    @(negedge clk);
    start     = st;
    nitems    = n;
    in_valid  = iv;
    out_ready = ordy;
    in_data   = iv ? (32'hC0DE_0000 + DATAW'(seq)) : 32'hDEAD_BEEF;
    #1;
    if (busy) busy_seen++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (k_stall) n_stall++;
    if (k_stall !== (out_valid & ~out_ready)) rule_bad++;
    if (in_ready && k_stall) rule_bad++;
    if (k_din !== in_data) rule_bad++;
    if (in_valid && in_ready) begin
      sb.push_back(in_data);
      if (first_acc < 0) first_acc = cyc;
      if (cyc < 64) acc_mask[cyc] = 1'b1;
      n_acc++;
      seq++;
    end
    if (out_valid) begin
      if (first_ov < 0) first_ov = cyc;
      if (cyc < 64) ov_mask[cyc] = 1'b1;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("emit_without_accept", 64'd1, 64'd0);
      else check("out_data", out_data, sb.pop_front() ^ KEY);
      n_emit++;
      last_emit = cyc;
    end
    cyc++;
  endtask

  initial begin
    seq = 0;
    rst = 1'b0; start = 1'b0; nitems = '0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_k_stall", k_stall, 0);
    check("rst_items_out", items_out, 0);
    @(negedge clk) rst = 1'b1;

    // 1: eight items at full rate.
    begin_test();
    for (int c = 0; c < 20; c++) step(c == 0, 16'd8, c >= 1, 1'b1);
    check("t1_latency", first_ov - first_acc, 4);
    check("t1_acc_mask", acc_mask, 64'h1FE);
    check("t1_ov_mask", ov_mask, 64'h1FE0);
    check("t1_n_emit", n_emit, 8);
    check("t1_done_cyc", done_cyc, 13);
    check("t1_n_done", n_done, 1);
    check("t1_items_out", items_out, 8);
    check("t1_rules", rule_bad, 0);

    // 2: downstream backpressure on cycles 6..9.
    begin_test();
    for (int c = 0; c < 25; c++) step(c == 0, 16'd6, c >= 1, !(c >= 6 && c <= 9));
    check("t2_n_stall", n_stall, 4);
    check("t2_acc_mask", acc_mask, 64'h43E);
    check("t2_ov_mask", ov_mask, 64'h7FE0);
    check("t2_n_emit", n_emit, 6);
    check("t2_done_cyc", done_cyc, 15);
    check("t2_items_out", items_out, 6);
    check("t2_rules", rule_bad, 0);

    // 3: alternating input valid leaves bubbles that must pass through unchanged.
    begin_test();
    for (int c = 0; c < 20; c++) step(c == 0, 16'd5, c[0], 1'b1);
    check("t3_acc_mask", acc_mask, 64'h2AA);
    check("t3_ov_mask", ov_mask, 64'h2AA0);
    check("t3_n_emit", n_emit, 5);
    check("t3_done_cyc", done_cyc, 14);
    check("t3_items_out", items_out, 5);
    check("t3_rules", rule_bad, 0);

    // 4: empty job goes straight to DONE.
    begin_test();
    for (int c = 0; c < 5; c++) step(c == 0, 16'd0, 1'b1, 1'b1);
    check("t4_done_cyc", done_cyc, 1);
    check("t4_n_done", n_done, 1);
    check("t4_busy_seen", busy_seen, 0);
    check("t4_n_acc", n_acc, 0);

    // 5: reset while three items are in flight, then a fresh two-item job.
    begin_test();
    for (int c = 0; c < 5; c++) step(c == 0, 16'd3, c >= 1, 1'b1);
    check("t5_pre_acc", n_acc, 3);
    check("t5_pre_emit", n_emit, 0);
    check("t5_pre_busy", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_k_stall", k_stall, 0);
    check("t5_rst_items_out", items_out, 0);
    @(negedge clk) rst = 1'b1;
    begin_test();
    for (int c = 0; c < 6; c++) step(1'b0, 16'd2, 1'b0, 1'b1);
    check("t5_no_done", n_done, 0);
    check("t5_no_out", ov_mask, 64'h0);
    begin_test();
    for (int c = 0; c < 12; c++) step(c == 0, 16'd2, c >= 1, 1'b1);
    check("t5_n_emit", n_emit, 2);
    check("t5_done_cyc", done_cyc, 7);
    check("t5_items_out", items_out, 2);

    // 6: start and nitems changes during RUN are ignored.
    begin_test();
    for (int c = 0; c < 14; c++) step(c == 0 || c == 2, (c == 0) ? 16'd3 : 16'd7, c >= 1, 1'b1);
    check("t6_n_acc", n_acc, 3);
    check("t6_n_emit", n_emit, 3);
    check("t6_done_cyc", done_cyc, 8);
    check("t6_n_done", n_done, 1);
    check("t6_items_out", items_out, 3);
    check("t6_rules", rule_bad, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
